bit_error_checker: RTL and testbench
====================================

Name: bit_error_checker

Overview:
- Bit-error comparator for the integrated BERT receive path.
- Compares the received word A against the locally generated reference word B on every qualified cycle and reports the per-bit error mask.
- Also reports the number of errored bits in the word, a saturating running error total, and a compared-bit total for BER computation.
- Sits between the PRBS checker/aligner and the BER reporting/readout logic.

Parameters:
- WIDTH, 8, data word width in bits (A, B, error).
- TOT_W, 8, width of the total_error accumulator.
- BITS_W, 32, width of the bits_compared accumulator.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- valid_in  input  1  A/B pair is valid this cycle.
- clear  input  1  synchronous clear of the accumulators.
- A  input  WIDTH  received data word.
- B  input  WIDTH  reference (expected) data word.
- error  output  WIDTH  registered bit-error mask, A XOR B.
- error_count  output  $clog2(WIDTH+1)  registered popcount of error.
- total_error  output  TOT_W  saturating accumulated errored-bit count.
- bits_compared  output  BITS_W  saturating accumulated compared-bit count.
- saturated  output  1  sticky flag: total_error or bits_compared has hit all-ones.
- valid_out  output  1  error/error_count updated this cycle.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset: while rst_n=0 at a clock edge, every output and internal register is 0. Reset overrides clear and valid_in.
- Latency: one clock. A/B sampled at edge N with valid_in=1 produce results after edge N:
  - error = A ^ B
  - error_count = popcount(A ^ B)
  - valid_out = 1
- valid_in=0: error and error_count hold their previous values; valid_out=0; accumulators hold.
- Accumulation on valid_in=1:
  - total_error <= min(total_error + error_count_new, 2^TOT_W-1)
  - bits_compared <= min(bits_compared + WIDTH, 2^BITS_W-1)
  - Sums are computed at TOT_W+1 / BITS_W+1 bits, then clamped. The counters never wrap.
- saturated: set when either accumulator reaches all-ones; sticky until clear or reset.
- clear=1 without valid_in: total_error, bits_compared and saturated go to 0. error and error_count are unchanged.
- clear=1 with valid_in=1 on the same cycle: clear takes effect first, then the current word accumulates.
  - total_error = popcount(A^B)
  - bits_compared = WIDTH
  - error/error_count/valid_out update normally.
- Inputs are unsigned bit patterns with no sign interpretation; e.g. -5 is 8'hFB.
- WIDTH must be >= 1. TOT_W must be >= $clog2(WIDTH+1).

Decomposition:
- Shared package bert_pkg holds:
  - default width constants WIDTH/TOT_W/BITS_W
  - a pure function sat_add(a, b, width) for clamped addition.
- One sub-module is natural: popcount, a combinational population count parameterized by WIDTH. It is implemented as an adder tree and instantiated once on A^B.

Test Plan:
- Reset: hold rst_n=0 with valid_in=1 and A=8'hFF, B=8'h00 → every output stays 0. Release reset → first valid result appears one cycle later.
- Sequence of five consecutive valid cycles, checking each result one cycle after its input:
  - A=8, B=7 → error=8'h0F, error_count=4, total_error=4.
  - A=100, B=120 → error=8'h1C, error_count=3, total_error=7.
  - A=250, B=250 → error=0, error_count=0, total_error=7.
  - A=0, B=-5 (8'hFB) → error=8'hFB, error_count=7, total_error=14.
  - A=-5, B=-5 → error=0, total_error=14.
  - bits_compared=40 after all five.
- valid_in gap: deassert valid_in for 3 cycles with changing A/B → error holds 0, valid_out=0, totals stay 14/40.
- Saturation: apply A=8'hFF, B=8'h00 for 32 cycles → total_error sticks at 255 (no wrap), saturated=1. valid_in idle → saturated stays 1.
- clear alone → total_error=0, bits_compared=0, saturated=0, error unchanged.
- clear with valid_in and A=8'h0F, B=8'h00 on the same cycle → total_error=4, bits_compared=8.
- Reset mid-run: assert rst_n=0 for one cycle during accumulation → all outputs 0 on the next cycle; accumulation restarts from 0.

Source files
------------

// File: rtl/bert_pkg.sv
// Shared constants and helpers for the BERT receive-path blocks.
// Provides default widths and a clamped (saturating) adder.
package bert_pkg;

    localparam int WIDTH  = 8;
    localparam int TOT_W  = 8;
    localparam int BITS_W = 32;

    // Adds a and b, clamping the result to the largest value that
    // fits in 'width' bits (width must be below 64).
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned width
    );
        logic [64:0] sum;
        logic [64:0] max;
        max = (65'd1 << width) - 65'd1;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > max) begin
            return max[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count built as a recursive adder tree.
// Ports: data (WIDTH bits) in, count ($clog2(WIDTH+1) bits) out.
module popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             data,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = data;
        end else begin : g_split
            localparam int LW  = WIDTH / 2;
            localparam int HW  = WIDTH - LW;
            localparam int LCW = $clog2(LW + 1);
            localparam int HCW = $clog2(HW + 1);

            logic [LCW-1:0] lo_cnt;
            logic [HCW-1:0] hi_cnt;

            popcount #(.WIDTH(LW)) u_lo (
                .data  (data[LW-1:0]),
                .count (lo_cnt)
            );

            popcount #(.WIDTH(HW)) u_hi (
                .data  (data[WIDTH-1:LW]),
                .count (hi_cnt)
            );

            assign count = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/bit_error_checker.sv
// Bit-error comparator: registered A^B mask, its popcount, and
// saturating errored-bit / compared-bit totals with a sticky flag.
// Ports: clk, rst_n (sync, active-low), valid_in, clear, A, B in;
//        error, error_count, total_error, bits_compared,
//        saturated, valid_out out (all registered).
module bit_error_checker
    import bert_pkg::*;
#(
    parameter int WIDTH  = bert_pkg::WIDTH,
    parameter int TOT_W  = bert_pkg::TOT_W,
    parameter int BITS_W = bert_pkg::BITS_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic [WIDTH-1:0]             error,
    output logic [$clog2(WIDTH+1)-1:0]   error_count,
    output logic [TOT_W-1:0]             total_error,
    output logic [BITS_W-1:0]            bits_compared,
    output logic                         saturated,
    output logic                         valid_out
);

    localparam int ECW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  diff;
    logic [ECW-1:0]    diff_cnt;
    logic [TOT_W-1:0]  tot_base;
    logic [BITS_W-1:0] bits_base;
    logic [63:0]       tot_sum;
    logic [63:0]       bits_sum;
    logic [TOT_W-1:0]  tot_next;
    logic [BITS_W-1:0] bits_next;
    logic              sat_base;

    assign diff = A ^ B;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .data  (diff),
        .count (diff_cnt)
    );

    // Clear wins first, so a same-cycle valid word accumulates from 0.
    always_comb begin
        tot_base  = clear ? '0 : total_error;
        bits_base = clear ? '0 : bits_compared;
        sat_base  = clear ? 1'b0 : saturated;
        tot_sum   = sat_add(64'(tot_base), 64'(diff_cnt), TOT_W);
        bits_sum  = sat_add(64'(bits_base), 64'(WIDTH), BITS_W);
        tot_next  = tot_sum[TOT_W-1:0];
        bits_next = bits_sum[BITS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error         <= '0;
            error_count   <= '0;
            total_error   <= '0;
            bits_compared <= '0;
            saturated     <= 1'b0;
            valid_out     <= 1'b0;
        end else if (valid_in) begin
            error         <= diff;
            error_count   <= diff_cnt;
            total_error   <= tot_next;
            bits_compared <= bits_next;
            saturated     <= sat_base | (&tot_next) | (&bits_next);
            valid_out     <= 1'b1;
        end else begin
            valid_out <= 1'b0;
            if (clear) begin
                total_error   <= '0;
                bits_compared <= '0;
                saturated     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_error_checker.sv
// Directed self-checking bench for bit_error_checker (default widths).
// Each task drives a scenario and checks outputs #1 after the edge.
module tb_bit_error_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        clear;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  error;
    logic [3:0]  error_count;
    logic [7:0]  total_error;
    logic [31:0] bits_compared;
    logic        saturated;
    logic        valid_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_error_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .clear         (clear),
        .A             (A),
        .B             (B),
        .error         (error),
        .error_count   (error_count),
        .total_error   (total_error),
        .bits_compared (bits_compared),
        .saturated     (saturated),
        .valid_out     (valid_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; valid_in = 1'b1;
        A = 8'hFF; B = 8'h00;
        tick(); tick();
        n_cmp++;
        if (error !== 8'h00) begin
            n_err++; $display("FAIL reset_error got %h want 00", error);
        end
        n_cmp++;
        if (error_count !== 4'd0) begin
            n_err++; $display("FAIL reset_count got %0d want 0", error_count);
        end
        n_cmp++;
        if (total_error !== 8'd0 || bits_compared !== 32'd0) begin
            n_err++;
            $display("FAIL reset_totals got %0d/%0d want 0/0",
                     total_error, bits_compared);
        end
        n_cmp++;
        if (saturated !== 1'b0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got sat=%b vo=%b want 0/0",
                     saturated, valid_out);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] va [5] = '{8'd8, 8'd100, 8'd250, 8'h00, 8'hFB};
        logic [7:0] vb [5] = '{8'd7, 8'd120, 8'd250, 8'hFB, 8'hFB};
        logic [7:0] ee [5] = '{8'h0F, 8'h1C, 8'h00, 8'hFB, 8'h00};
        logic [3:0] ec [5] = '{4'd4, 4'd3, 4'd0, 4'd7, 4'd0};
        logic [7:0] et [5] = '{8'd4, 8'd7, 8'd7, 8'd14, 8'd14};
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; A = va[i]; B = vb[i];
            tick();
            n_cmp++;
            if (error !== ee[i] || valid_out !== 1'b1) begin
                n_err++;
                $display("FAIL seq%0d_error got %h vo=%b want %h vo=1",
                         i, error, valid_out, ee[i]);
            end
            n_cmp++;
            if (error_count !== ec[i]) begin
                n_err++;
                $display("FAIL seq%0d_count got %0d want %0d",
                         i, error_count, ec[i]);
            end
            n_cmp++;
            if (total_error !== et[i]) begin
                n_err++;
                $display("FAIL seq%0d_total got %0d want %0d",
                         i, total_error, et[i]);
            end
        end
        n_cmp++;
        if (bits_compared !== 32'd40) begin
            n_err++; $display("FAIL seq_bits got %0d want 40", bits_compared);
        end
    endtask

    task automatic test_gap();
        logic [7:0] ga [3] = '{8'h12, 8'hA5, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b0; A = ga[i]; B = ~ga[i];
            tick();
            n_cmp++;
            if (error !== 8'h00 || error_count !== 4'd0 ||
                valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL gap%0d_hold got %h/%0d vo=%b want 00/0 vo=0",
                         i, error, error_count, valid_out);
            end
            n_cmp++;
            if (total_error !== 8'd14 || bits_compared !== 32'd40) begin
                n_err++;
                $display("FAIL gap%0d_totals got %0d/%0d want 14/40",
                         i, total_error, bits_compared);
            end
        end
    endtask

    task automatic test_saturation();
        valid_in = 1'b1; A = 8'hFF; B = 8'h00;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 29) begin
                n_cmp++;
                if (total_error !== 8'd254 || saturated !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_pre got %0d sat=%b want 254 sat=0",
                             total_error, saturated);
                end
            end
        end
        n_cmp++;
        if (total_error !== 8'd255 || saturated !== 1'b1) begin
            n_err++;
            $display("FAIL sat_total got %0d sat=%b want 255 sat=1",
                     total_error, saturated);
        end
        n_cmp++;
        if (bits_compared !== 32'd296 || error_count !== 4'd8) begin
            n_err++;
            $display("FAIL sat_bits got %0d/%0d want 296/8",
                     bits_compared, error_count);
        end
        valid_in = 1'b0;
        tick();
        n_cmp++;
        if (saturated !== 1'b1 || valid_out !== 1'b0 ||
            total_error !== 8'd255) begin
            n_err++;
            $display("FAIL sat_idle got sat=%b vo=%b tot=%0d want 1/0/255",
                     saturated, valid_out, total_error);
        end
    endtask

    task automatic test_clear();
        valid_in = 1'b0; clear = 1'b1;
        tick();
        n_cmp++;
        if (total_error !== 8'd0 || bits_compared !== 32'd0 ||
            saturated !== 1'b0) begin
            n_err++;
            $display("FAIL clear_acc got %0d/%0d sat=%b want 0/0/0",
                     total_error, bits_compared, saturated);
        end
        n_cmp++;
        if (error !== 8'hFF || error_count !== 4'd8) begin
            n_err++;
            $display("FAIL clear_error got %h/%0d want FF/8",
                     error, error_count);
        end
        valid_in = 1'b1; A = 8'h0F; B = 8'h00;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (total_error !== 8'd4 || bits_compared !== 32'd8) begin
            n_err++;
            $display("FAIL clear_valid got %0d/%0d want 4/8",
                     total_error, bits_compared);
        end
        n_cmp++;
        if (error !== 8'h0F || valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL clear_valid_err got %h vo=%b want 0F vo=1",
                     error, valid_out);
        end
    endtask

    task automatic test_reset_midrun();
        valid_in = 1'b1; A = 8'h03; B = 8'h00;
        tick();
        n_cmp++;
        if (total_error !== 8'd6 || bits_compared !== 32'd16) begin
            n_err++;
            $display("FAIL mid_pre got %0d/%0d want 6/16",
                     total_error, bits_compared);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (error !== 8'h00 || total_error !== 8'd0 ||
            bits_compared !== 32'd0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got %h/%0d/%0d vo=%b want 00/0/0 vo=0",
                     error, total_error, bits_compared, valid_out);
        end
        rst_n = 1'b1; A = 8'h01; B = 8'h00;
        tick();
        n_cmp++;
        if (error !== 8'h01 || total_error !== 8'd1 ||
            bits_compared !== 32'd8) begin
            n_err++;
            $display("FAIL mid_restart got %h/%0d/%0d want 01/1/8",
                     error, total_error, bits_compared);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_gap();
        test_saturation();
        test_clear();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
